// File: rtl/sigma_pkg.sv
// Shared types and constants for the SigmaCore memory-side blocks.
package sigma_pkg;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_WAIT,
    MR_ACCESS,
    MR_RESP
  } mem_resp_state_t;

  localparam int MEM_WAIT_STATES_DEFAULT = 1;
  localparam int WORD_BYTES              = 4;

endpackage

// File: rtl/sigma_sram_1rw.sv
// Single-port synchronous SRAM, 32-bit words, byte-enable writes, registered read data.
module sigma_sram_1rw #(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata only moves on a read, so it holds the last loaded word otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/sigma_mem_responder.sv
// Memory responder for the SigmaCore: valid/ready request, programmable wait states,
// one-cycle response pulse. Optional address checking under `MEM_ERR_CHECK_EN.
module sigma_mem_responder
  import sigma_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = MEM_WAIT_STATES_DEFAULT,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_resp_state_t state_q, state_d;
  logic [3:0]    cnt_q;
  logic          write_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          err_q;
  logic          zero_q;
  logic          req_err;
  logic          sram_en;
  logic [31:0]   sram_rdata;

`ifdef MEM_ERR_CHECK_EN
  assign req_err  = (req_addr[1:0] != 2'b00) ||
                    (req_addr >= 32'(DEPTH_WORDS * WORD_BYTES));
  assign resp_err = (state_q == MR_RESP) && err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign req_err  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_en    = 1'b0;
    case (state_q)
      MR_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (WAIT_STATES > 0) ? MR_WAIT : MR_ACCESS;
      end
      MR_WAIT: begin
        if (cnt_q <= 4'd1) state_d = MR_ACCESS;
      end
      MR_ACCESS: begin
        sram_en = !err_q;
        state_d = MR_RESP;
      end
      MR_RESP: begin
        resp_valid = 1'b1;
        state_d    = MR_IDLE;
      end
      default: state_d = MR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MR_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == MR_IDLE && req_valid) begin
        write_q <= req_write;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        err_q   <= req_err;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == MR_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == MR_ACCESS) zero_q <= write_q || err_q;
    end
  end

  // Read data is masked rather than cleared so the SRAM output register
  // can double as the response holding register.
  assign resp_rdata = zero_q ? '0 : sram_rdata;

  sigma_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (write_q),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

endmodule
